exponent_accelerator_sw_poller: RTL
===================================

EXPONENT_ACCELERATOR_SW_POLLER -- requirements
Module: exponent_accelerator_sw_poller

Interface
REQ-001 SHALL have parameter POLL_CYCLES, default 1000, meaning idle cycles between polls (range 1..65535).
REQ-002 SHALL have parameter SW_WIDTH, default 10, meaning the number of switch bits taken from readdata[SW_WIDTH-1:0].
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port poll_en, input, 1 bit: polling permitted while high.
REQ-006 SHALL have port avm_address, output, 2 bits: Avalon-MM read address, constant 0.
REQ-007 SHALL have port avm_read, output, 1 bit: Avalon-MM read request.
REQ-008 SHALL have port avm_waitrequest, input, 1 bit: slave stall; a read is accepted in a cycle where avm_read=1 and avm_waitrequest=0.
REQ-009 SHALL have port avm_readdata, input, 32 bits: read data, valid exactly 1 cycle after acceptance (fixed read latency 1).
REQ-010 SHALL have port sw_value, output, SW_WIDTH bits: reported switch value.
REQ-011 SHALL have port sw_valid, output, 1 bit: sw_value holds an unconsumed change.
REQ-012 SHALL have port sw_ready, input, 1 bit: consumer accepts sw_value when sw_valid=1 and sw_ready=1.

Function
REQ-013 SHALL implement states IDLE, REQ, LAT, CMP and HOLD.
REQ-014 IDLE SHALL decrement a poll counter each cycle while poll_en=1, and SHALL freeze the counter while poll_en=0.
REQ-015 IDLE SHALL go to REQ in the cycle after the counter reaches 0.
REQ-016 REQ SHALL hold avm_read=1 and avm_address=0 until acceptance, then go to LAT.
REQ-017 avm_read SHALL be 1 only in REQ.
REQ-018 While in REQ, deasserting poll_en SHALL NOT abort the read.
REQ-019 LAT SHALL capture avm_readdata[SW_WIDTH-1:0] into a sample register, then go to CMP.
REQ-020 In LAT, upper readdata bits SHALL be ignored.
REQ-021 CMP SHALL go to HOLD with sw_value<=sample when sample differs from the last reported value or no value has been reported since reset.
REQ-022 Otherwise, CMP SHALL go to IDLE.
REQ-023 HOLD SHALL assert sw_valid=1 and keep sw_value stable until handshake.
REQ-024 On handshake, HOLD SHALL set last-reported to sw_value and go to IDLE with sw_valid=0 in the next cycle.
REQ-025 No polling SHALL occur while in HOLD (no queue; intermediate switch changes are dropped and only the value at the next poll is seen).
REQ-026 Every entry into IDLE SHALL reload the counter to POLL_CYCLES-1.
REQ-027 Poll period with sw_ready tied high and no stall SHALL be POLL_CYCLES+3 cycles (IDLE count + REQ + LAT + CMP).
REQ-028 sw_ready asserted while sw_valid=0 SHALL have no effect.
REQ-029 sw_valid SHALL never deassert without a handshake, except by reset.

Reset
REQ-030 On reset assertion, regardless of clk, the block SHALL immediately set state=IDLE, counter=POLL_CYCLES-1, avm_read=0, avm_address=0, sw_valid=0, sw_value=0, sample=0, and clear the reported-since-reset flag.
REQ-031 Reset mid-read SHALL abandon the read, and readdata arriving after reset release SHALL be ignored.
REQ-032 After reset deassertion, the first poll SHALL begin POLL_CYCLES cycles later (given poll_en=1).

Verification
REQ-033 With POLL_CYCLES=4, slave returning 0x155 with no stall, sw_ready=1 -> first avm_read 4 cycles after reset release; sw_valid pulses with sw_value=0x155; a later identical read produces no sw_valid.
REQ-034 With waitrequest high for 5 cycles -> avm_read held 6 cycles with avm_address=0; the value is captured from the cycle after acceptance.
REQ-035 With sw_ready=0 and readdata changing 0x001 -> 0x3FF -> sw_valid stays high and sw_value stays 0x001; no avm_read while held; after sw_ready=1, the next poll reports 0x3FF.
REQ-036 With readdata=0xFFFFF2AA -> sw_value=0x2AA.
REQ-037 With poll_en=0 for 10 cycles mid-count -> counter frozen, no avm_read; the count resumes from the held value.
REQ-038 With reset pulsed while in REQ -> avm_read=0 asynchronously; the next read of the previous value is still reported, because the reported flag was cleared.

Source files
------------

// File: rtl/exponent_accelerator_sw_poller.sv
// -----------------------------------------------------------------------------
// exponent_accelerator_sw_poller
//
// Purpose:
//   Polls a switch register over an Avalon-MM read master at a fixed interval.
//   Each poll reads address 0 and keeps readdata[SW_WIDTH-1:0]. A value is
//   offered to the consumer only when it differs from the last value the
//   consumer accepted, or when nothing has been accepted since reset. Only
//   one value is offered at a time: while it waits to be accepted, polling
//   stops and any switch changes in the meantime are not seen.
//
// Parameters:
//   POLL_CYCLES : idle cycles between polls (1..65535)
//   SW_WIDTH    : number of switch bits taken from avm_readdata
//
// Ports:
//   clk             in   single clock, rising edge
//   reset           in   asynchronous, active-high reset
//   poll_en         in   polling permitted while high (freezes the idle count)
//   avm_address     out  Avalon-MM read address, always 0
//   avm_read        out  Avalon-MM read request, high only in REQ
//   avm_waitrequest in   slave stall
//   avm_readdata    in   read data, valid one cycle after acceptance
//   sw_value        out  reported switch value
//   sw_valid        out  sw_value holds a change not yet accepted
//   sw_ready        in   consumer ready
//
// Handshakes:
//   Avalon read: a read is accepted in a cycle where avm_read=1 and
//   avm_waitrequest=0; data is sampled in the following cycle.
//   Output: a transfer occurs in a cycle where sw_valid=1 and sw_ready=1.
//   sw_valid stays high and sw_value stable until that transfer; sw_ready
//   while sw_valid=0 is ignored.
// -----------------------------------------------------------------------------
module exponent_accelerator_sw_poller #(
    parameter int POLL_CYCLES = 1000,
    parameter int SW_WIDTH    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                poll_en,
    output logic [1:0]          avm_address,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    input  logic [31:0]         avm_readdata,
    output logic [SW_WIDTH-1:0] sw_value,
    output logic                sw_valid,
    input  logic                sw_ready
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_LAT  = 3'd2;
    localparam logic [2:0] ST_CMP  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam logic [15:0] CNT_RELOAD = 16'(POLL_CYCLES - 1);

    logic [2:0]          state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [SW_WIDTH-1:0] sample_q, sample_d;
    logic [SW_WIDTH-1:0] value_q, value_d;
    logic [SW_WIDTH-1:0] last_q, last_d;
    logic                valid_q, valid_d;
    logic                reported_q, reported_d;

    // Upper readdata bits carry no switch information.
    logic unused_upper;
    assign unused_upper = ^avm_readdata[31:SW_WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        value_d    = value_q;
        last_d     = last_q;
        valid_d    = valid_q;
        reported_d = reported_q;

        case (state_q)
            ST_IDLE: begin
                // The count only moves while polling is permitted; the poll
                // launches in the cycle after the count has reached zero.
                if (poll_en) begin
                    if (cnt_q == 16'd0) begin
                        state_d = ST_REQ;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            ST_REQ: begin
                // Once issued, a read runs to completion regardless of poll_en.
                if (!avm_waitrequest) begin
                    state_d = ST_LAT;
                end
            end
            ST_LAT: begin
                sample_d = avm_readdata[SW_WIDTH-1:0];
                state_d  = ST_CMP;
            end
            ST_CMP: begin
                if (!reported_q || (sample_q != last_q)) begin
                    value_d = sample_q;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (sw_ready) begin
                    last_d     = value_q;
                    reported_d = 1'b1;
                    valid_d    = 1'b0;
                    cnt_d      = CNT_RELOAD;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                cnt_d   = CNT_RELOAD;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_RELOAD;
            sample_q   <= '0;
            value_q    <= '0;
            last_q     <= '0;
            valid_q    <= 1'b0;
            reported_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            value_q    <= value_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            reported_q <= reported_d;
        end
    end

    // Decoded from the state register so reset drops the request at once.
    assign avm_read    = (state_q == ST_REQ);
    assign avm_address = 2'b00;
    assign sw_value    = value_q;
    assign sw_valid    = valid_q;

endmodule
